// File: rtl/fetch_queue_stage.sv
// fetch_queue_stage
//   Instruction fetch front end. It generates the PC, issues reads to a
//   synchronous instruction memory (one-cycle read latency) and buffers the
//   returned words in a DEPTH-entry circular queue that decode drains.
//   Decode stalls are absorbed by the queue. Branch redirects flush the queue
//   and drop the in-flight response.
//
//   Optional feature macro: FETCH_QUEUE_BYPASS_EN
//     When defined, a response that arrives while the queue is empty is
//     presented straight to decode in the same cycle. This cuts the
//     empty-queue latency from 2 cycles to 1.
//
// Ports:
//   clk            in   clock, all state updates on the rising edge
//   reset          in   synchronous active-high reset
//   mem_addr_out   out  instruction memory read address (the PC register)
//   mem_re_out     out  read issued this cycle
//   mem_data_in    in   read data, valid the cycle after the issue
//   redirect_in    in   branch taken: flush and refetch
//   redirect_pc_in in   redirect target
//   stall_in       in   decode cannot accept this cycle
//   instr_out      out  instruction at the queue head
//   pc_out         out  PC of instr_out
//   valid_out      out  instr_out / pc_out are valid
module fetch_queue_stage #(
  parameter int unsigned         ADDR_W   = 32,
  parameter int unsigned         INSTR_W  = 32,
  parameter int unsigned         DEPTH    = 4,
  parameter logic [ADDR_W-1:0]   PC_STEP  = ADDR_W'(4),
  parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  mem_addr_out,
  output logic               mem_re_out,
  input  logic [INSTR_W-1:0] mem_data_in,
  input  logic               redirect_in,
  input  logic [ADDR_W-1:0]  redirect_pc_in,
  input  logic               stall_in,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               valid_out
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  // Architectural state
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  resp_pc;
  logic [CNT_W-1:0]   count;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic               inflight;

  // Queue storage: never reset, only the pointers and count are
  logic [INSTR_W-1:0] q_instr [DEPTH];
  logic [ADDR_W-1:0]  q_pc    [DEPTH];

  // Per-cycle control
  logic               issue;
  logic               enq;
  logic               deq;
  logic [CNT_W:0]     occupancy;

  // Words held plus the one still in flight. Issuing only below DEPTH
  // guarantees every response has a free slot when it lands.
  assign occupancy = {1'b0, count} + (CNT_W + 1)'(inflight);

  assign issue        = !reset && !redirect_in && (occupancy < DEPTH_C);
  assign mem_re_out   = issue;
  assign mem_addr_out = pc;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypass;

  // An empty queue with a live response presents that response directly.
  // The response is consumed here if decode takes it. Otherwise it is
  // enqueued as usual.
  assign bypass = (count == '0) && inflight && !redirect_in;

  always_comb begin
    valid_out = (count != '0) || bypass;
    instr_out = q_instr[rd_ptr];
    pc_out    = q_pc[rd_ptr];
    if (bypass) begin
      instr_out = mem_data_in;
      pc_out    = resp_pc;
    end
  end

  assign deq = (count != '0) && !stall_in && !redirect_in;
  assign enq = inflight && !redirect_in && !(bypass && !stall_in);
`else
  always_comb begin
    valid_out = (count != '0);
    instr_out = q_instr[rd_ptr];
    pc_out    = q_pc[rd_ptr];
  end

  // The head shown during a redirect cycle is never counted as consumed.
  assign deq = valid_out && !stall_in && !redirect_in;
  assign enq = inflight && !redirect_in;
`endif

  // PC, pointers, count and in-flight tracking.
  // Priority order: reset, then redirect, then normal issue/enqueue/dequeue.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_PC;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      inflight <= 1'b0;
    end else if (redirect_in) begin
      pc       <= redirect_pc_in;
      count    <= '0;
      rd_ptr   <= wr_ptr;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc <= pc + PC_STEP;
      end
      if (enq) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // PC of the outstanding request, paired with its data on return
  always_ff @(posedge clk) begin
    if (issue) begin
      resp_pc <= pc;
    end
  end

  // enq is already false under redirect. The reset term drops a response
  // that lands on the reset edge.
  always_ff @(posedge clk) begin
    if (!reset && enq) begin
      q_instr[wr_ptr] <= mem_data_in;
      q_pc[wr_ptr]    <= resp_pc;
    end
  end

endmodule

// File: doc/fetch_queue_stage.md
Name: fetch_queue_stage

Overview:
- Parametrised successor to the single-register fetch/decode front end: generates the PC, issues reads to a synchronous instruction memory and buffers returned words in a DEPTH-entry queue.
- Sits between instruction memory and the decode stage.
- Absorbs decode stalls without losing in-flight fetches.
- Handles branch redirects by flushing the queue and discarding the stale in-flight response.

Parameters:
ADDR_W, 32, PC / memory address width
INSTR_W, 32, instruction word width
DEPTH, 4, queue entries (power of two, >= 2)
PC_STEP, 4, PC increment per fetch (ADDR_W wide)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous active-high reset
mem_addr_out  out  ADDR_W  instruction memory read address (equals PC register)
mem_re_out  out  1  read issued this cycle
mem_data_in  in  INSTR_W  memory read data, valid the cycle after the issue
redirect_in  in  1  branch taken: flush and refetch
redirect_pc_in  in  ADDR_W  redirect target
stall_in  in  1  decode cannot accept this cycle
instr_out  out  INSTR_W  instruction at queue head
pc_out  out  ADDR_W  PC of instr_out
valid_out  out  1  instr_out / pc_out valid

Behaviour:
- Reset (sampled high at an edge):
  - pc <= RESET_PC; count <= 0; rd_ptr <= 0; wr_ptr <= 0; inflight <= 0.
  - Outputs: valid_out = 0, mem_re_out = 0, mem_addr_out = RESET_PC.
  - Queue storage is not cleared.
  - Reset overrides redirect, issue and dequeue; an in-flight response after reset is dropped (inflight = 0).
- Issue (combinational): mem_re_out = !reset && !redirect_in && (count + inflight < DEPTH).
  - On issue: pc <= pc + PC_STEP, modulo 2^ADDR_W (wrap allowed); inflight <= 1; the issued PC is latched as resp_pc.
  - Otherwise inflight <= 0.
  - At most one request per cycle. Sustained throughput is 1 instruction/cycle when not stalled.
- Response: when inflight == 1, mem_data_in and resp_pc are written at wr_ptr at the edge. wr_ptr increments modulo DEPTH.
  - Because of the issue condition, a response always has a free slot; overflow is impossible and the bench must assert it never occurs.
- Dequeue: valid_out = (count != 0). instr_out/pc_out = entry at rd_ptr.
  - When valid_out && !stall_in: rd_ptr increments modulo DEPTH.
  - count update: +1 on enqueue only, -1 on dequeue only, unchanged on both.
- Redirect, in the redirect_in cycle:
  - pc <= redirect_pc_in; count <= 0; rd_ptr <= wr_ptr; inflight <= 0.
  - Any response arriving at that edge is discarded, and no issue occurs.
  - The entry presented in that cycle is not counted as consumed by decode, even if stall_in = 0.
  - The first fetch of the target issues the following cycle, so valid_out returns 2 cycles after that issue.
  - Back-to-back redirects: the last one wins.
- Latency:
  - First issue occurs in the first cycle after reset deasserts.
  - valid_out rises 2 edges after an issue into an empty queue.
- Stall: while stall_in = 1, outputs hold. Fetching continues until count + inflight == DEPTH, then mem_re_out = 0 until a dequeue.

Optional Feature:
- Macro FETCH_QUEUE_BYPASS_EN.
- Defined:
  - When count == 0 and inflight == 1 (response not discarded by redirect), valid_out = 1, instr_out = mem_data_in, pc_out = resp_pc, combinationally.
  - If stall_in = 0 the word is consumed and not enqueued; if stall_in = 1 it is enqueued normally.
  - Empty-queue latency drops to 1 cycle after issue.
- Undefined: no bypass path; latency is 2 as above.

Test Plan:
- Reset with RESET_PC=0x100 and mem_data = addr: mem_addr_out 0x100, 0x104, 0x108… on consecutive cycles; valid_out first high 2 cycles after first issue (1 with bypass); instr/pc pairs 0x100/0x100, 0x104/0x104 every cycle thereafter.
- Hold stall_in=1 for 10 cycles from reset with DEPTH=4: mem_re_out drops after 4 issues; count saturates at 4; on release, 0x100..0x10C drain in order, then fetch resumes at 0x110 with no gap or duplicate.
- Pulse redirect_in to 0x400 while inflight=1 and count=2: next valid instruction has pc_out=0x400; no word from the old stream appears after the redirect.
- Redirect in the same cycle as stall_in=0 with valid_out=1: that head entry is dropped; the stream resumes at the target.
- Run 20 instructions with random stall_in, DEPTH=4: in-order, gap-free PC sequence (pointer wrap exercised); no overflow; PC wraps 0xFFFFFFFC -> 0x0 when started there.
- Assert reset mid-stream with count=3 and inflight=1: the next edge gives valid_out=0 and mem_addr_out=RESET_PC; the stale response is never output.
